// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RISC-V pipeline.
// Selects forwarded operands, runs the ALU, resolves branches straight back to
// fetch, and holds the EX/MEM pipeline register (updated on the falling edge).
// Ports:
//   clk, rst (async, active-low)
//   E-side inputs : control bits, ALUControlE, RD1E/RD2E, ImmExtE, PCE,
//                   PCPlus4E, RDE, ForwardAE/ForwardBE, ResultW
//   Combinational : PCSrcE, PCTargetE
//   Registered    : ALUResultM, WriteDataM, PCPlus4M, RDM, RegWriteM,
//                   MemWriteM, ResultSrcM
module execute_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RDE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RDM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Operand A forwarding: 01 = writeback result, 10 = EX/MEM result.
  always_comb begin
    src_a = RD1E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  // Operand B forwarding; this value (never the immediate) is also store data.
  always_comb begin
    fwd_b = RD2E;
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;

  // ALU; add/sub wrap, unused codes yield zero.
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = XLEN'($signed(src_a) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + ImmExtE;

  // EX/MEM pipeline register, falling edge to match the ID/EX register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RDM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
    end else begin
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
      RDM        <= RDE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed-vector bench for execute_stage.
// Inputs change #1 after a falling edge; M outputs are checked #1 after the
// next falling edge, combinational outputs #1 after the inputs change.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RDE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RDM;
  logic        RegWriteM, MemWriteM, ResultSrcM;

  int checks   = 0;
  int failures = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RDE(RDE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_defaults();
    RegWriteE = 0; MemWriteE = 0; BranchE = 0; ALUSrcE = 0; ResultSrcE = 0;
    ALUControlE = 3'b000; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0;
    PCPlus4E = 0; RDE = 0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0;
  endtask

  task automatic next_fall();
    @(negedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    ALUSrcE = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUControlE = op; RD1E = a; RD2E = b;
    next_fall();
    check_eq(tag, ALUResultM, exp);
  endtask

  initial begin
    set_defaults();
    rst = 1'b0;
    // Arbitrary inputs held while in reset.
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RDE = 5'd9;
    RD1E = 32'h11; RD2E = 32'h22; PCPlus4E = 32'h1234;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_alu", ALUResultM, 32'h0);
    check_eq("rst_wd",  WriteDataM, 32'h0);
    check_eq("rst_pc4", PCPlus4M, 32'h0);
    check_eq("rst_rd",  32'(RDM), 32'h0);
    check_eq("rst_ctl", {29'h0, RegWriteM, MemWriteM, ResultSrcM}, 32'h0);

    rst = 1'b1;
    next_fall();
    check_eq("rel_alu", ALUResultM, 32'h33);
    check_eq("rel_wd",  WriteDataM, 32'h22);
    check_eq("rel_pc4", PCPlus4M, 32'h1234);
    check_eq("rel_rd",  32'(RDM), 32'd9);
    check_eq("rel_ctl", {29'h0, RegWriteM, MemWriteM, ResultSrcM}, 32'h7);

    set_defaults();
    alu_vec("add",      3'b000, 32'd5, 32'd7, 32'd12);
    check_eq("add_wd", WriteDataM, 32'd7);
    alu_vec("sub",      3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("slt",      3'b101, 32'd5, 32'd7, 32'd1);
    alu_vec("slt_neg",  3'b101, 32'h8000_0000, 32'd1, 32'd1);
    alu_vec("slt_ge",   3'b101, 32'd7, 32'd5, 32'd0);
    alu_vec("and",      3'b010, 32'd5, 32'd7, 32'd5);
    alu_vec("or",       3'b011, 32'd5, 32'd8, 32'd13);
    alu_vec("op111",    3'b111, 32'd5, 32'd7, 32'd0);
    alu_vec("op100",    3'b100, 32'd5, 32'd7, 32'd0);
    alu_vec("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1);

    // Immediate operand; store data stays RD2E.
    ALUSrcE = 1; ImmExtE = 32'hFFFF_FFFC; RD1E = 32'h100; RD2E = 32'hABCD;
    ALUControlE = 3'b000;
    next_fall();
    check_eq("imm_alu", ALUResultM, 32'hFC);
    check_eq("imm_wd",  WriteDataM, 32'hABCD);

    // Back-to-back forwarding: produce 0x20 then consume it.
    alu_vec("fwd_prod", 3'b000, 32'h20, 32'h0, 32'h20);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h3;
    RD1E = 32'h999; RD2E = 32'h777; ALUControlE = 3'b001;
    next_fall();
    check_eq("fwd_alu", ALUResultM, 32'h1D);
    check_eq("fwd_wd",  WriteDataM, 32'h3);

    // ForwardBE=10 uses EX/MEM result (0x1D) as store data and operand.
    ForwardAE = 2'b00; ForwardBE = 2'b10; RD1E = 32'h50; ALUControlE = 3'b001;
    next_fall();
    check_eq("fwdb10_alu", ALUResultM, 32'h33);
    check_eq("fwdb10_wd",  WriteDataM, 32'h1D);

    // Code 11 falls back to register-file operands.
    ForwardAE = 2'b11; ForwardBE = 2'b11; ResultW = 32'h1;
    RD1E = 32'h30; RD2E = 32'h10; ALUControlE = 3'b001;
    next_fall();
    check_eq("fwd11_alu", ALUResultM, 32'h20);
    check_eq("fwd11_wd",  WriteDataM, 32'h10);

    // Branch resolution, zero latency.
    set_defaults();
    BranchE = 1; RD1E = 32'd9; RD2E = 32'd9; ALUControlE = 3'b001;
    PCE = 32'h40; ImmExtE = 32'h10;
    #1;
    check_eq("br_taken", 32'(PCSrcE), 32'd1);
    check_eq("br_tgt",   PCTargetE, 32'h50);
    RD2E = 32'd8;
    #1;
    check_eq("br_not",   32'(PCSrcE), 32'd0);
    RD2E = 32'd9; BranchE = 0;
    #1;
    check_eq("br_nobr",  32'(PCSrcE), 32'd0);
    PCE = 32'hFFFF_FFF8; ImmExtE = 32'h10;
    #1;
    check_eq("tgt_wrap", PCTargetE, 32'h8);

    // Pass-through, stable across the rising edge.
    set_defaults();
    next_fall();
    RDE = 5'd17; RegWriteE = 1; MemWriteE = 0; ResultSrcE = 1;
    PCPlus4E = 32'h44;
    next_fall();
    check_eq("pt_rd",  32'(RDM), 32'd17);
    check_eq("pt_ctl", {29'h0, RegWriteM, MemWriteM, ResultSrcM}, 32'h5);
    check_eq("pt_pc4", PCPlus4M, 32'h44);
    RDE = 5'd3; RegWriteE = 0; ResultSrcE = 0; MemWriteE = 1;
    PCPlus4E = 32'h88;
    @(posedge clk);
    #1;
    check_eq("pt_hold_rd",  32'(RDM), 32'd17);
    check_eq("pt_hold_pc4", PCPlus4M, 32'h44);
    next_fall();
    check_eq("pt_next_ctl", {29'h0, RegWriteM, MemWriteM, ResultSrcM}, 32'h2);

    // Mid-operation async reset clears immediately; branch path stays live.
    RD1E = 32'd4; RD2E = 32'd4; ALUControlE = 3'b000;
    next_fall();
    #2;
    PCE = 32'h100; ImmExtE = 32'h20; BranchE = 1; ALUControlE = 3'b001;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_alu", ALUResultM, 32'h0);
    check_eq("mid_rst_pc4", PCPlus4M, 32'h0);
    check_eq("mid_rst_tgt", PCTargetE, 32'h120);
    check_eq("mid_rst_br",  32'(PCSrcE), 32'd1);
    #10;
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RISC-V pipeline. It takes the decode-stage outputs (register operands, immediate, PC values, control bits) and performs the ALU operation with operand forwarding. It resolves branches combinationally back to fetch, and registers results and control into the EX/MEM pipeline register consumed by the memory stage.

## Interface
Parameters
- XLEN, 32, datapath width.

Ports
- clk  in  1  pipeline clock; EX/MEM register updates on the falling edge (same edge as the ID/EX register).
- rst  in  1  reset; asynchronous, active-low.
- RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE  in  1 each  control from ID/EX.
- ALUControlE  in  3  ALU operation select.
- RD1E, RD2E  in  XLEN  register-file operands.
- ImmExtE, PCE, PCPlus4E  in  XLEN  immediate, instruction PC, PC+4.
- RDE  in  5  destination register.
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
- ResultW  in  XLEN  writeback-stage result (forward source).
- PCSrcE  out  1  branch taken, combinational, to fetch.
- PCTargetE  out  XLEN  branch target, combinational, to fetch.
- ALUResultM  out  XLEN  registered ALU result; also a forward source.
- WriteDataM  out  XLEN  registered store data.
- PCPlus4M  out  XLEN  registered PC+4.
- RDM  out  5  registered destination register.
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control.

## Operation
- SrcA mux on ForwardAE:
  - 00: RD1E
  - 01: ResultW
  - 10: ALUResultM
  - 11: RD1E
- Forwarded B (FwdB) mux on ForwardBE uses the same encoding on RD2E.
- SrcB = ALUSrcE ? ImmExtE : FwdB.
- ALU on ALUControlE:
  - 000: add
  - 001: sub
  - 010: and
  - 011: or
  - 101: signed slt (result 1 or 0, zero-extended)
  - any other code: result 0
- Add and sub wrap modulo 2^XLEN; no overflow output.
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + ImmExtE, wrapping modulo 2^XLEN.
- EX/MEM register captures, on each falling clk edge:
  - ALU result → ALUResultM
  - FwdB → WriteDataM (store data is never the immediate)
  - PCPlus4E, RDE, RegWriteE, MemWriteE, ResultSrcE → corresponding M outputs
- No stall or flush input. Bubbles arrive as all-zero control from ID/EX and propagate unchanged.

## Timing
- Reset: when rst=0, every registered output (ALUResultM, WriteDataM, PCPlus4M, RDM, RegWriteM, MemWriteM, ResultSrcM) is 0 immediately, independent of clk.
- Reset release: the first capture is the first falling edge with rst=1.
- Reset mid-operation: in-flight EX/MEM contents are discarded. PCSrcE and PCTargetE remain combinational functions of their inputs during reset.
- Latency: one falling edge from E inputs to M outputs.
- PCSrcE and PCTargetE are valid in the same cycle as their E inputs, with zero latency.
- Forward path from ALUResultM: uses the value registered at the previous falling edge, i.e. the back-to-back dependency case.

## Test plan
- Reset: drive arbitrary E inputs with rst=0 across several edges → all M outputs stay 0. Release rst → next falling edge captures the inputs.
- Add/sub/slt: RD1E=5, RD2E=7, ALUSrcE=0.
  - ALUControlE=000 → ALUResultM=12.
  - 001 → 0xFFFFFFFE.
  - 101 → 1.
  - RD1E=0x80000000, RD2E=1, slt → 1.
- Immediate and store data: ALUSrcE=1, ImmExtE=0xFFFFFFFC, RD1E=0x100, RD2E=0xABCD, op add → ALUResultM=0xFC, WriteDataM=0xABCD.
- Forwarding:
  - ForwardAE=10 with ALUResultM=0x20, ForwardBE=01 with ResultW=0x3, op sub → next ALUResultM=0x1D.
  - ForwardAE=11 → RD1E is used.
- Branch: BranchE=1, RD1E=RD2E=9, op sub, PCE=0x40, ImmExtE=0x10 → PCSrcE=1 and PCTargetE=0x50 in the same cycle. With RD2E=8 → PCSrcE=0.
- Pass-through: RDE=17, RegWriteE=1, MemWriteE=0, ResultSrcE=1, PCPlus4E=0x44 → M outputs match after one falling edge and do not change on the rising edge.
